// File: rtl/csc_rgb_ycbcr_stream_if.sv
// Pixel stream bundle: valid/ready handshake, three colour components,
// frame coordinates, side-band address and the colour-conversion mode.
interface csc_rgb_ycbcr_stream_if #(
  parameter int BIT_WIDTH = 8,
  parameter int V_BITW    = 9,
  parameter int H_BITW    = 10,
  parameter int ADDR_BITW = 21
);
  logic                 valid;
  logic                 ready;
  logic [BIT_WIDTH-1:0] c0;
  logic [BIT_WIDTH-1:0] c1;
  logic [BIT_WIDTH-1:0] c2;
  logic [V_BITW-1:0]    vcnt;
  logic [H_BITW-1:0]    hcnt;
  logic [ADDR_BITW-1:0] addr;
  logic [1:0]           mode;

  modport master (output valid, c0, c1, c2, vcnt, hcnt, addr, mode, input ready);
  modport slave  (input valid, c0, c1, c2, vcnt, hcnt, addr, mode, output ready);
endinterface

// File: rtl/csc_rgb_ycbcr_stream.sv
// Four-stage streaming RGB->YCbCr converter (BT.709 / BT.601 full range, or RGB bypass)
// with a global valid/ready stall and frame-aligned mode latching.
module csc_rgb_ycbcr_stream #(
  parameter int BIT_WIDTH    = 8,
  parameter int FRAC_BITW    = 10,
  parameter int FRAME_HEIGHT = 480,
  parameter int FRAME_WIDTH  = 640,
  parameter int ADDR_BITW    = 21
) (
  input logic                        clk,
  input logic                        rst,
  csc_rgb_ycbcr_stream_if.slave      i_pix,
  csc_rgb_ycbcr_stream_if.master     o_pix
);
  localparam int V_BITW = $clog2(FRAME_HEIGHT);
  localparam int H_BITW = $clog2(FRAME_WIDTH);
  localparam int CW     = BIT_WIDTH + FRAC_BITW + 3;

  // Weights are given in millionths; rounds half away from zero.
  function automatic logic signed [CW-1:0] f_coef(input longint w_e6);
    longint m;
    longint q;
    m = w_e6 * (longint'(1) <<< FRAC_BITW);
    if (m >= 0) q = (m + 64'sd500000) / 64'sd1000000;
    else        q = -((-m + 64'sd500000) / 64'sd1000000);
    return q[CW-1:0];
  endfunction

  localparam logic signed [CW-1:0] K709 [9] = '{
    f_coef(212600),  f_coef(715200),  f_coef(72200),
    f_coef(-114572), f_coef(-385428), f_coef(500000),
    f_coef(500000),  f_coef(-454153), f_coef(-45847)};
  localparam logic signed [CW-1:0] K601 [9] = '{
    f_coef(299000),  f_coef(587000),  f_coef(114000),
    f_coef(-168736), f_coef(-331264), f_coef(500000),
    f_coef(500000),  f_coef(-418688), f_coef(-81312)};

  localparam logic signed [CW-1:0] ONE  = 1;
  localparam logic signed [CW-1:0] BIAS = CW'(2 ** (BIT_WIDTH - 1));
  localparam logic signed [CW-1:0] MAXV = CW'(2 ** BIT_WIDTH - 1);

  function automatic logic [BIT_WIDTH-1:0] f_finish(input logic signed [CW-1:0] s,
                                                    input logic bias);
    logic signed [CW-1:0] v;
    v = ((s >>> (FRAC_BITW - 1)) + ONE) >>> 1;
    if (bias) v = v + BIAS;
    if (v < 0)    return '0;
    if (v > MAXV) return '1;
    return v[BIT_WIDTH-1:0];
  endfunction

  logic [1:0]            r_active_mode;
  logic                  r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
  logic [BIT_WIDTH-1:0]  r_s1_c [3];
  logic [BIT_WIDTH-1:0]  r_s2_c [3];
  logic [BIT_WIDTH-1:0]  r_s3_c [3];
  logic [BIT_WIDTH-1:0]  r_s4_c [3];
  logic [V_BITW-1:0]     r_s1_v, r_s2_v, r_s3_v, r_s4_v;
  logic [H_BITW-1:0]     r_s1_h, r_s2_h, r_s3_h, r_s4_h;
  logic [ADDR_BITW-1:0]  r_s1_a, r_s2_a, r_s3_a, r_s4_a;
  logic [1:0]            r_s1_m, r_s2_m, r_s3_m, r_s4_m;
  logic signed [CW-1:0]  r_s2_p [9];
  logic signed [CW-1:0]  r_s3_sum [3];

  logic                  w_adv;
  logic                  w_sof;
  logic [1:0]            w_mode_in;
  logic signed [CW-1:0]  w_ext  [3];
  logic signed [CW-1:0]  w_k    [9];
  logic signed [CW-1:0]  w_prod [9];
  logic [BIT_WIDTH-1:0]  w_res  [3];

  assign w_adv       = o_pix.ready | ~r_s4_valid;
  assign i_pix.ready = w_adv;
  assign w_sof       = i_pix.valid & w_adv & (i_pix.vcnt == '0) & (i_pix.hcnt == '0);
  // The frame-start pixel itself already uses the newly requested mode.
  assign w_mode_in   = w_sof ? i_pix.mode : r_active_mode;

  always_comb begin
    for (int j = 0; j < 3; j++) w_ext[j] = {{(CW-BIT_WIDTH){1'b0}}, r_s1_c[j]};
    for (int i = 0; i < 9; i++) begin
      w_k[i]    = (r_s1_m == 2'd1) ? K601[i] : K709[i];
      w_prod[i] = w_ext[i % 3] * w_k[i];
    end
    for (int j = 0; j < 3; j++)
      w_res[j] = r_s3_m[1] ? r_s3_c[j] : f_finish(r_s3_sum[j], j != 0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active_mode <= 2'd0;
      r_s1_valid <= 1'b0; r_s2_valid <= 1'b0; r_s3_valid <= 1'b0; r_s4_valid <= 1'b0;
      for (int j = 0; j < 3; j++) begin
        r_s1_c[j] <= '0; r_s2_c[j] <= '0; r_s3_c[j] <= '0; r_s4_c[j] <= '0;
        r_s3_sum[j] <= '0;
      end
      for (int i = 0; i < 9; i++) r_s2_p[i] <= '0;
      r_s1_v <= '0; r_s2_v <= '0; r_s3_v <= '0; r_s4_v <= '0;
      r_s1_h <= '0; r_s2_h <= '0; r_s3_h <= '0; r_s4_h <= '0;
      r_s1_a <= '0; r_s2_a <= '0; r_s3_a <= '0; r_s4_a <= '0;
      r_s1_m <= '0; r_s2_m <= '0; r_s3_m <= '0; r_s4_m <= '0;
    end else begin
      if (w_sof) r_active_mode <= i_pix.mode;
      if (w_adv) begin
        r_s1_valid <= i_pix.valid;
        r_s1_c[0]  <= i_pix.c0;
        r_s1_c[1]  <= i_pix.c1;
        r_s1_c[2]  <= i_pix.c2;
        r_s1_v     <= i_pix.vcnt;
        r_s1_h     <= i_pix.hcnt;
        r_s1_a     <= i_pix.addr;
        r_s1_m     <= w_mode_in;

        r_s2_valid <= r_s1_valid;
        for (int i = 0; i < 9; i++) r_s2_p[i] <= w_prod[i];
        r_s2_c <= r_s1_c; r_s2_v <= r_s1_v; r_s2_h <= r_s1_h; r_s2_a <= r_s1_a; r_s2_m <= r_s1_m;

        r_s3_valid <= r_s2_valid;
        for (int j = 0; j < 3; j++)
          r_s3_sum[j] <= r_s2_p[3*j] + r_s2_p[3*j+1] + r_s2_p[3*j+2];
        r_s3_c <= r_s2_c; r_s3_v <= r_s2_v; r_s3_h <= r_s2_h; r_s3_a <= r_s2_a; r_s3_m <= r_s2_m;

        r_s4_valid <= r_s3_valid;
        r_s4_c <= w_res; r_s4_v <= r_s3_v; r_s4_h <= r_s3_h; r_s4_a <= r_s3_a; r_s4_m <= r_s3_m;
      end
    end
  end

  assign o_pix.valid = r_s4_valid;
  assign o_pix.c0    = r_s4_c[0];
  assign o_pix.c1    = r_s4_c[1];
  assign o_pix.c2    = r_s4_c[2];
  assign o_pix.vcnt  = r_s4_v;
  assign o_pix.hcnt  = r_s4_h;
  assign o_pix.addr  = r_s4_a;
  assign o_pix.mode  = r_s4_m;

endmodule

// File: tb/tb_csc_rgb_ycbcr_stream.sv
// Directed bench for csc_rgb_ycbcr_stream: hand-computed BT.709/BT.601 vectors,
// latency, stall behaviour, frame-aligned mode switching and mid-stream reset.
module tb_csc_rgb_ycbcr_stream;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [7:0]  y;
    logic [7:0]  cb;
    logic [7:0]  cr;
    logic [8:0]  v;
    logic [9:0]  h;
    logic [20:0] a;
    logic [1:0]  m;
  } pix_t;

  pix_t q_out[$];

  csc_rgb_ycbcr_stream_if #(.BIT_WIDTH(8), .V_BITW(9), .H_BITW(10), .ADDR_BITW(21)) ipix ();
  csc_rgb_ycbcr_stream_if #(.BIT_WIDTH(8), .V_BITW(9), .H_BITW(10), .ADDR_BITW(21)) opix ();

  csc_rgb_ycbcr_stream dut (.clk(clk), .rst(rst), .i_pix(ipix), .o_pix(opix));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && opix.valid && opix.ready)
      q_out.push_back('{opix.c0, opix.c1, opix.c2, opix.vcnt, opix.hcnt, opix.addr, opix.mode});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic pix_t mk(input int y, cb, cr, v, h, a, m);
    return '{8'(y), 8'(cb), 8'(cr), 9'(v), 10'(h), 21'(a), 2'(m)};
  endfunction

  task automatic send(input int r, g, b, v, h, a, m);
    int n = 0;
    ipix.valid = 1'b1;
    ipix.c0 = 8'(r); ipix.c1 = 8'(g); ipix.c2 = 8'(b);
    ipix.vcnt = 9'(v); ipix.hcnt = 10'(h); ipix.addr = 21'(a); ipix.mode = 2'(m);
    #1;
    while (!ipix.ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!ipix.ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", ipix.ready);
    end
    @(negedge clk);
    ipix.valid = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ipix.valid = 1'b0; opix.ready = 1'b1;
    ipix.c0 = 0; ipix.c1 = 0; ipix.c2 = 0; ipix.vcnt = 0; ipix.hcnt = 0; ipix.addr = 0; ipix.mode = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (opix.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", opix.valid); end
    checks++;
    if ({opix.c0, opix.c1, opix.c2, opix.vcnt, opix.hcnt, opix.addr, opix.mode} !== 57'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0",
                         {opix.c0, opix.c1, opix.c2, opix.vcnt, opix.hcnt, opix.addr, opix.mode});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ipix.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ipix.ready); end
  endtask

  task automatic test_bt709();
    pix_t exp[3];
    exp[0] = mk(255, 128, 128, 0, 0, 100, 0);
    exp[1] = mk(0, 128, 128, 0, 1, 101, 0);
    exp[2] = mk(54, 99, 255, 0, 2, 102, 0);
    q_out.delete();
    send(255, 255, 255, 0, 0, 100, 0);
    send(0, 0, 0, 0, 1, 101, 0);
    send(255, 0, 0, 0, 2, 102, 0);
    drain();
    checks++;
    if (q_out.size() != 3) begin errors++; $display("FAIL bt709_count: got %0d want 3", q_out.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_out[i] !== exp[i]) begin errors++; $display("FAIL bt709_pix%0d: got %h want %h", i, q_out[i], exp[i]); end
    end
  endtask

  task automatic test_bt601_red();
    pix_t exp0 = mk(76, 85, 255, 0, 0, 200, 1);
    q_out.delete();
    send(255, 0, 0, 0, 0, 200, 1);
    drain();
    checks++;
    if (q_out.size() != 1) begin errors++; $display("FAIL bt601_count: got %0d want 1", q_out.size()); end
    else begin
      checks++;
      if (q_out[0] !== exp0) begin errors++; $display("FAIL bt601_red: got %h want %h", q_out[0], exp0); end
    end
  endtask

  task automatic test_bypass_latency();
    q_out.delete();
    ipix.valid = 1'b1; ipix.c0 = 8'd10; ipix.c1 = 8'd200; ipix.c2 = 8'd37;
    ipix.vcnt = 0; ipix.hcnt = 0; ipix.addr = 21'd300; ipix.mode = 2'd2;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      ipix.valid = 1'b0;
      checks++;
      if (opix.valid !== 1'b0) begin errors++; $display("FAIL bypass_early_clk%0d: got %b want 0", k, opix.valid); end
    end
    @(negedge clk);
    checks++;
    if ({opix.valid, opix.c0, opix.c1, opix.c2, opix.mode} !== {1'b1, 8'd10, 8'd200, 8'd37, 2'd2}) begin
      errors++; $display("FAIL bypass_out: got %h want %h",
                         {opix.valid, opix.c0, opix.c1, opix.c2, opix.mode}, {1'b1, 8'd10, 8'd200, 8'd37, 2'd2});
    end
    drain();
  endtask

  task automatic test_stall();
    int sent = 0;
    int e;
    logic exp_rdy, exp_val;
    q_out.delete();
    for (int n = 0; n < 18; n++) begin
      opix.ready = !(n >= 6 && n <= 8);
      if (sent < 8) begin
        ipix.valid = 1'b1; ipix.c0 = 8'(sent * 20 + 5); ipix.c1 = 8'(255 - sent * 9); ipix.c2 = 8'(sent * 3);
        ipix.vcnt = 0; ipix.hcnt = 10'(sent); ipix.addr = 21'(1000 + sent * 7); ipix.mode = 2'd2;
      end else ipix.valid = 1'b0;
      #1;
      exp_rdy = !(n >= 6 && n <= 8);
      exp_val = (n >= 4 && n <= 14);
      e = (n <= 6) ? n - 4 : ((n <= 9) ? 2 : n - 7);
      checks++;
      if (ipix.ready !== exp_rdy) begin errors++; $display("FAIL stall_ready_n%0d: got %b want %b", n, ipix.ready, exp_rdy); end
      checks++;
      if (opix.valid !== exp_val) begin errors++; $display("FAIL stall_valid_n%0d: got %b want %b", n, opix.valid, exp_val); end
      if (exp_val) begin
        checks++;
        if ({opix.c0, opix.c1, opix.c2, opix.hcnt, opix.addr} !==
            {8'(e * 20 + 5), 8'(255 - e * 9), 8'(e * 3), 10'(e), 21'(1000 + e * 7)}) begin
          errors++; $display("FAIL stall_data_n%0d: got %h want %h", n,
                             {opix.c0, opix.c1, opix.c2, opix.hcnt, opix.addr},
                             {8'(e * 20 + 5), 8'(255 - e * 9), 8'(e * 3), 10'(e), 21'(1000 + e * 7)});
        end
      end
      if (exp_rdy && sent < 8) sent++;
      @(negedge clk);
    end
    ipix.valid = 1'b0; opix.ready = 1'b1;
    checks++;
    if (q_out.size() != 8) begin errors++; $display("FAIL stall_count: got %0d want 8", q_out.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++;
      if (q_out[i].h !== 10'(i) || q_out[i].y !== 8'(i * 20 + 5)) begin
        errors++; $display("FAIL stall_order%0d: got h=%0d y=%0d want h=%0d y=%0d", i, q_out[i].h, q_out[i].y, i, i * 20 + 5);
      end
    end
  endtask

  task automatic test_mode_switch();
    pix_t exp[6];
    exp[0] = mk(255, 128, 128, 0, 0, 400, 0);
    exp[1] = mk(54, 99, 255, 5, 99, 401, 0);
    exp[2] = mk(54, 99, 255, 5, 100, 402, 0);
    exp[3] = mk(54, 99, 255, 5, 101, 403, 0);
    exp[4] = mk(76, 85, 255, 0, 0, 404, 1);
    exp[5] = mk(76, 85, 255, 0, 1, 405, 1);
    q_out.delete();
    send(255, 255, 255, 0, 0, 400, 0);
    send(255, 0, 0, 5, 99, 401, 0);
    send(255, 0, 0, 5, 100, 402, 1);
    send(255, 0, 0, 5, 101, 403, 1);
    send(255, 0, 0, 0, 0, 404, 1);
    send(255, 0, 0, 0, 1, 405, 0);
    drain();
    checks++;
    if (q_out.size() != 6) begin errors++; $display("FAIL mode_count: got %0d want 6", q_out.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++;
      if (q_out[i] !== exp[i]) begin errors++; $display("FAIL mode_pix%0d: got %h want %h", i, q_out[i], exp[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    pix_t exp0 = mk(54, 99, 255, 5, 7, 600, 0);
    q_out.delete();
    opix.ready = 1'b0;
    send(255, 0, 0, 0, 0, 500, 1);
    send(255, 0, 0, 0, 1, 501, 1);
    send(255, 0, 0, 0, 2, 502, 1);
    @(negedge clk);
    checks++;
    if ({opix.valid, ipix.ready, opix.c0, opix.mode} !== {1'b1, 1'b0, 8'd76, 2'd1}) begin
      errors++; $display("FAIL midrst_stalled: got %h want %h", {opix.valid, ipix.ready, opix.c0, opix.mode},
                         {1'b1, 1'b0, 8'd76, 2'd1});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({opix.valid, opix.c0, opix.c1, opix.c2, opix.vcnt, opix.hcnt, opix.addr, opix.mode} !== 58'd0) begin
      errors++; $display("FAIL midrst_outputs: got %h want 0",
                         {opix.valid, opix.c0, opix.c1, opix.c2, opix.vcnt, opix.hcnt, opix.addr, opix.mode});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; opix.ready = 1'b1;
    #1;
    checks++;
    if (ipix.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ipix.ready); end
    @(negedge clk);
    drain();
    checks++;
    if (q_out.size() != 0) begin errors++; $display("FAIL midrst_stale: got %0d pixels want 0", q_out.size()); end
    send(255, 0, 0, 5, 7, 600, 1);
    drain();
    checks++;
    if (q_out.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d want 1", q_out.size()); end
    else begin
      checks++;
      if (q_out[0] !== exp0) begin errors++; $display("FAIL midrst_mode709: got %h want %h", q_out[0], exp0); end
    end
  endtask

  initial begin
    test_reset();
    test_bt709();
    test_bt601_red();
    test_bypass_latency();
    test_stall();
    test_mode_switch();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
